// File: rtl/game_state_controller_if.sv
// Bundles the obstacle/bird/score inputs and the game-level outputs of game_state_controller.
interface game_state_controller_if;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SCORE_W = 7;

  logic               tick;
  logic               flap_btn;
  logic [COORD_W-1:0] bird_y;
  logic [COORD_W-1:0] obs1x, obs1y, obs2x, obs2y, obs3x, obs3y;
  logic [SCORE_W-1:0] score;
  logic               reset_physics;
  logic               physics_en;
  logic               collision;
  logic [1:0]         state;
  logic [SCORE_W-1:0] high_score;
  logic               flap_pulse;

  modport master (
    output tick, flap_btn, bird_y, obs1x, obs1y, obs2x, obs2y, obs3x, obs3y, score,
    input  reset_physics, physics_en, collision, state, high_score, flap_pulse
  );

  modport slave (
    input  tick, flap_btn, bird_y, obs1x, obs1y, obs2x, obs2y, obs3x, obs3y, score,
    output reset_physics, physics_en, collision, state, high_score, flap_pulse
  );
endinterface

// File: rtl/game_state_controller.sv
// Game-level FSM: flap synchronisation, per-tick bird/pipe/ground/ceiling collision,
// death delay and session high score.
module game_state_controller #(
  parameter int unsigned BIRD_X      = 100,
  parameter int unsigned BIRD_W      = 16,
  parameter int unsigned BIRD_H      = 12,
  parameter int unsigned PIPE_W      = 40,
  parameter int unsigned GAP_H       = 90,
  parameter int unsigned GROUND_Y    = 440,
  parameter int unsigned DEATH_TICKS = 60
) (
  input logic clk,
  input logic reset_n,
  game_state_controller_if.slave bus
);
  localparam int unsigned AW      = 11;
  localparam int unsigned SCORE_W = 7;
  localparam int unsigned CNT_W   = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

  localparam logic [AW-1:0]    BIRD_L    = AW'(BIRD_X);
  localparam logic [AW-1:0]    BIRD_R    = AW'(BIRD_X + BIRD_W - 1);
  localparam logic [AW-1:0]    BIRD_DY   = AW'(BIRD_H - 1);
  localparam logic [AW-1:0]    PIPE_DX   = AW'(PIPE_W - 1);
  localparam logic [AW-1:0]    GAP_DY    = AW'(GAP_H - 1);
  localparam logic [AW-1:0]    GROUND    = AW'(GROUND_Y);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEATH_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               coll_q, coll_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic               rphys_q, rphys_d;
  logic               pen_q, pen_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic               flap_pulse_q;
  logic               hit_c;

  // Pipe N hit: horizontal overlap with the bird column and bird box not inside the gap.
  function automatic logic pipe_hit(input logic [AW-1:0] ox, input logic [AW-1:0] oy,
                                    input logic [AW-1:0] top, input logic [AW-1:0] bot);
    logic overlap;
    overlap  = (ox <= BIRD_R) && ((ox + PIPE_DX) >= BIRD_L);
    pipe_hit = overlap && ((top < oy) || (bot > (oy + GAP_DY)));
  endfunction

  always_comb begin
    logic [AW-1:0] top;
    logic [AW-1:0] bot;
    top   = AW'(bus.bird_y);
    bot   = top + BIRD_DY;
    hit_c = pipe_hit(AW'(bus.obs1x), AW'(bus.obs1y), top, bot)
          | pipe_hit(AW'(bus.obs2x), AW'(bus.obs2y), top, bot)
          | pipe_hit(AW'(bus.obs3x), AW'(bus.obs3y), top, bot)
          | (bot >= GROUND)
          | (top == '0);
  end

  // Two-flop synchroniser followed by a rising-edge detector on the flap button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      flap_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= bus.flap_btn;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      flap_pulse_q <= sync2_q & ~sync3_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    hs_d    = hs_q;
    unique case (state_q)
      IDLE: begin
        coll_d = 1'b0;
        if (flap_pulse_q) state_d = PLAY;
      end
      PLAY: begin
        if (bus.tick && hit_c) begin
          coll_d  = 1'b1;
          cnt_d   = '0;
          state_d = DYING;
        end
      end
      DYING: begin
        if (bus.tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = OVER;
            if (bus.score > hs_q) hs_d = bus.score;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OVER: begin
        if (flap_pulse_q) begin
          state_d = IDLE;
          coll_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs follow the next state so they change on the same edge as the state.
    rphys_d = (state_d == IDLE);
    pen_d   = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      hs_q    <= '0;
      rphys_q <= 1'b1;
      pen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      hs_q    <= hs_d;
      rphys_q <= rphys_d;
      pen_q   <= pen_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.collision     = coll_q;
  assign bus.high_score    = hs_q;
  assign bus.reset_physics = rphys_q;
  assign bus.physics_en    = pen_q;
  assign bus.flap_pulse    = flap_pulse_q;
endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: stimulus queues expected snapshots,
// a negedge monitor pops one per flap pulse, state change or explicit probe.
module tb_game_state_controller;
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_OVER = 2'd3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  game_state_controller_if bus();
  game_state_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       coll;
    logic       pen;
    logic       rp;
    logic [6:0] hs;
    logic       fp;
  } exp_t;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   probe_cnt  = 0;
  int   probe_seen = 0;
  logic [1:0] prev_state = 2'd0;

  task automatic push(input string n, input logic [1:0] s, input logic c, input logic pen,
                      input logic rp, input logic [6:0] hs, input logic fp);
    exp_t e;
    e.name = n; e.st = s; e.coll = c; e.pen = pen; e.rp = rp; e.hs = hs; e.fp = fp;
    q.push_back(e);
  endtask

  task automatic check_one();
    exp_t e;
    logic [12:0] act, want;
    n_checks++;
    act = {bus.state, bus.collision, bus.physics_en, bus.reset_physics, bus.high_score, bus.flap_pulse};
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event @%0t: state=%0d coll=%0b pen=%0b rp=%0b hs=%0d fp=%0b, nothing expected",
               $time, bus.state, bus.collision, bus.physics_en, bus.reset_physics, bus.high_score, bus.flap_pulse);
    end else begin
      e = q.pop_front();
      want = {e.st, e.coll, e.pen, e.rp, e.hs, e.fp};
      if (act !== want) begin
        n_fail++;
        $display("FAIL %s @%0t: got state=%0d coll=%0b pen=%0b rp=%0b hs=%0d fp=%0b, want state=%0d coll=%0b pen=%0b rp=%0b hs=%0d fp=%0b",
                 e.name, $time, bus.state, bus.collision, bus.physics_en, bus.reset_physics, bus.high_score,
                 bus.flap_pulse, e.st, e.coll, e.pen, e.rp, e.hs, e.fp);
      end
    end
  endtask

  // Monitor: any flap pulse or state change is a DUT output event.
  always @(negedge clk) begin
    if (bus.flap_pulse === 1'b1 || bus.state !== prev_state) check_one();
    prev_state = bus.state;
    if (probe_cnt != probe_seen) begin
      probe_seen++;
      check_one();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  task automatic press(input int hold);
    bus.flap_btn = 1'b1;
    cyc(hold);
    bus.flap_btn = 1'b0;
    cyc(4);
  endtask

  task automatic probe(input string n, input logic [1:0] s, input logic c, input logic pen,
                       input logic rp, input logic [6:0] hs);
    push(n, s, c, pen, rp, hs, 1'b0);
    probe_cnt++;
    cyc(1);
  endtask

  initial begin
    bus.tick = 1'b0; bus.flap_btn = 1'b0; bus.score = 7'd0; bus.bird_y = 10'd220;
    bus.obs1x = 10'd600; bus.obs1y = 10'd200;
    bus.obs2x = 10'd600; bus.obs2y = 10'd200;
    bus.obs3x = 10'd600; bus.obs3y = 10'd200;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    probe("reset_state", S_IDLE, 0, 0, 1, 7'd0);

    push("first_flap_pulse", S_IDLE, 0, 0, 1, 7'd0, 1);
    push("idle_to_play", S_PLAY, 0, 1, 0, 7'd0, 0);
    press(5);

    bus.bird_y = 10'd220; bus.obs1x = 10'd110; bus.obs1y = 10'd200;
    do_tick(); cyc(1);
    probe("clean_pass", S_PLAY, 0, 1, 0, 7'd0);

    bus.bird_y = 10'd195; bus.obs1x = 10'd116;
    do_tick(); cyc(1);
    probe("x116_no_overlap", S_PLAY, 0, 1, 0, 7'd0);

    bus.bird_y = 10'd428; bus.obs1x = 10'd600;
    do_tick(); cyc(1);
    probe("y428_no_ground", S_PLAY, 0, 1, 0, 7'd0);

    bus.score = 7'd5; bus.bird_y = 10'd195; bus.obs1x = 10'd115;
    push("x115_pipe_hit", S_DYING, 1, 0, 0, 7'd0, 0);
    do_tick(); cyc(2);

    push("dying_single_pulse", S_DYING, 1, 0, 0, 7'd0, 1);
    press(100);
    probe("dying_ignores_flap", S_DYING, 1, 0, 0, 7'd0);

    repeat (59) do_tick();
    cyc(1);
    probe("dying_after_59", S_DYING, 1, 0, 0, 7'd0);
    push("over_hs5", S_OVER, 1, 0, 0, 7'd5, 0);
    do_tick(); cyc(2);

    push("over_pulse", S_OVER, 1, 0, 0, 7'd5, 1);
    push("over_to_idle", S_IDLE, 0, 0, 1, 7'd5, 0);
    press(5);

    push("game2_pulse", S_IDLE, 0, 0, 1, 7'd5, 1);
    push("game2_play", S_PLAY, 0, 1, 0, 7'd5, 0);
    press(5);
    bus.score = 7'd3; bus.bird_y = 10'd429; bus.obs1x = 10'd600;
    push("y429_ground_hit", S_DYING, 1, 0, 0, 7'd5, 0);
    do_tick(); cyc(2);
    push("over_keeps_hs5", S_OVER, 1, 0, 0, 7'd5, 0);
    repeat (60) do_tick();
    cyc(2);

    push("game2_over_pulse", S_OVER, 1, 0, 0, 7'd5, 1);
    push("game2_to_idle", S_IDLE, 0, 0, 1, 7'd5, 0);
    press(5);
    push("game3_pulse", S_IDLE, 0, 0, 1, 7'd5, 1);
    push("game3_play", S_PLAY, 0, 1, 0, 7'd5, 0);
    press(5);

    // Flap pulse and a ceiling-hit tick land in the same PLAY cycle.
    bus.bird_y = 10'd0;
    push("flap_with_hit_pulse", S_PLAY, 0, 1, 0, 7'd5, 1);
    push("hit_wins_over_flap", S_DYING, 1, 0, 0, 7'd5, 0);
    bus.flap_btn = 1'b1;
    cyc(3);
    do_tick();
    cyc(2);
    bus.flap_btn = 1'b0;
    cyc(4);

    push("mid_game_reset", S_IDLE, 0, 0, 1, 7'd0, 0);
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(4);

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: %0d expected events never observed, next=%s", q.size(), q[0].name);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
